// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and the
// latched memory command. Command fields are sized to the 16x4 prog_mem geometry.
package mem_arb_pkg;

    localparam int MEM_AW = 4;
    localparam int MEM_DW = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between the CPU and loader requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties alternate using the last-winner pointer; otherwise CPU wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ld_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_winner,
`endif
    output owner_t winner
);

    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && ld_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // The requester that did not win most recently takes the tie.
            winner = (last_winner == OWN_CPU) ? OWN_LD : OWN_CPU;
`else
            winner = OWN_CPU;
`endif
        end else if (ld_req) begin
            winner = OWN_LD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port req/gnt arbiter in front of the single-port data memory, one access per clock.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed CPU priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_out
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     winner;
    mem_cmd_t   cmd_q, cmd_d;
    logic       any_req;
    logic       cpu_rvalid_q, ld_rvalid_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t     last_q;
`endif

    assign any_req = cpu_req | ld_req;

    arb_pick u_pick (
        .cpu_req     (cpu_req),
        .ld_req      (ld_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_winner (last_q),
`endif
        .winner      (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_CPU;
            cmd_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            ld_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            // Read data lands one cycle after the gnt cycle, matching the memory's address register.
            cpu_rvalid_q <= (state_q == ARB_ACCESS) && (owner_q == OWN_CPU) && !cmd_q.we;
            ld_rvalid_q  <= (state_q == ARB_ACCESS) && (owner_q == OWN_LD) && !cmd_q.we;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_LD;
        end else if (any_req) begin
            last_q <= winner;
        end
    end
`endif

    always_comb begin
        state_d = ARB_IDLE;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        if (any_req) begin
            state_d = ARB_ACCESS;
            owner_d = winner;
            if (winner == OWN_LD) begin
                cmd_d = '{we: ld_we, addr: ld_addr, wdata: ld_wdata};
            end else begin
                cmd_d = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        cpu_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        if (state_q == ARB_ACCESS) begin
            mem_we   = cmd_q.we;
            mem_addr = cmd_q.addr;
            mem_data = cmd_q.wdata;
            cpu_gnt  = (owner_q == OWN_CPU);
            ld_gnt   = (owner_q == OWN_LD);
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign ld_rvalid  = ld_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? mem_out : '0;
    assign ld_rdata   = ld_rvalid_q  ? mem_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 16x4 registered-read memory.
// Expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            due;
    } sb_entry_t;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    sb_entry_t sb_q[$];
    vec_t      vecs[9];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_out    (mem_out)
    );

    // Memory model: write and address register share the clock edge.
    logic [DW-1:0] mem [16] = '{default: '0};
    logic [AW-1:0] rd_addr_q = '0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        rd_addr_q <= mem_addr;
    end

    assign mem_out = mem[rd_addr_q];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushRead(input bit port, input logic [DW-1:0] data);
        sb_entry_t e;
        e.port = port;
        e.data = data;
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Issue one access on a port and check the gnt cycle; reads go to the scoreboard.
    task automatic applyStimulus(input bit port, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        int waited = 0;
        bit got = 1'b0;
        if (port == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end
        while (!got && waited < 10) begin
            @(posedge clk); #1;
            waited++;
            if ((port == 1'b0 && cpu_gnt) || (port == 1'b1 && ld_gnt)) begin
                got = 1'b1;
                checkOutput("gnt_latency", waited, 1);
                checkOutput("other_gnt", int'(port ? cpu_gnt : ld_gnt), 0);
                checkOutput("gnt_mem_we", int'(mem_we), int'(we));
                checkOutput("gnt_mem_addr", int'(mem_addr), int'(addr));
                if (we) checkOutput("gnt_mem_data", int'(mem_data), int'(wdata));
                else    pushRead(port, exp_rdata);
            end
        end
        if (!got) checkOutput("gnt_timeout", 0, 1);
        cpu_req = 1'b0;
        ld_req  = 1'b0;
    endtask

    // Scoreboard monitor: every sample either retires the due read or expects silence.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk); #1;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                if (e.port == 1'b0) begin
                    checkOutput("cpu_rvalid", int'(cpu_rvalid), 1);
                    checkOutput("cpu_rdata", int'(cpu_rdata), int'(e.data));
                    checkOutput("ld_rvalid_quiet", int'(ld_rvalid), 0);
                end else begin
                    checkOutput("ld_rvalid", int'(ld_rvalid), 1);
                    checkOutput("ld_rdata", int'(ld_rdata), int'(e.data));
                    checkOutput("cpu_rvalid_quiet", int'(cpu_rvalid), 0);
                end
            end else begin
                checkOutput("no_rvalid", int'({cpu_rvalid, ld_rvalid}), 0);
                checkOutput("rdata_idle_zero", int'({cpu_rdata, ld_rdata}), 0);
            end
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                checkOutput("rvalid_missing", 0, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit exp_cpu;

        vecs[0] = '{1'b0, 1'b1, 4'd3,  4'hA, 4'h0};
        vecs[1] = '{1'b0, 1'b0, 4'd3,  4'h0, 4'hA};
        vecs[2] = '{1'b0, 1'b0, 4'd7,  4'h0, 4'h7};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 4'h0, 4'hF};
        vecs[4] = '{1'b0, 1'b1, 4'd7,  4'h5, 4'h0};
        vecs[5] = '{1'b1, 1'b0, 4'd7,  4'h0, 4'h5};
        vecs[6] = '{1'b1, 1'b1, 4'd0,  4'hC, 4'h0};
        vecs[7] = '{1'b0, 1'b0, 4'd0,  4'h0, 4'hC};
        vecs[8] = '{1'b1, 1'b0, 4'd3,  4'h0, 4'hA};

        // Reset held with both requesters active.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd0;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("rst_cpu_gnt", int'(cpu_gnt), 0);
            checkOutput("rst_ld_gnt", int'(ld_gnt), 0);
            checkOutput("rst_mem_we", int'(mem_we), 0);
            checkOutput("rst_mem_addr", int'(mem_addr), 0);
            checkOutput("rst_rvalid", int'({cpu_rvalid, ld_rvalid}), 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("first_tie_cpu_gnt", int'(cpu_gnt), 1);
        checkOutput("first_tie_ld_gnt", int'(ld_gnt), 0);
        pushRead(1'b0, 4'h0);
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        @(posedge clk); #1;

        // Loader preload, request held with advancing address.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'd1; ld_wdata = 4'd1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            checkOutput("preload_ld_gnt", int'(ld_gnt), 1);
            checkOutput("preload_mem_we", int'(mem_we), 1);
            checkOutput("preload_mem_addr", int'(mem_addr), k);
            checkOutput("preload_mem_data", int'(mem_data), k);
            if (k < 15) begin
                ld_addr  = AW'(k + 1);
                ld_wdata = DW'(k + 1);
            end else begin
                ld_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        checkOutput("preload_done_ld_gnt", int'(ld_gnt), 0);

        // Sustained tie: both requesters read and hold req for six grants.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 4'd9;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_cpu = (i % 2 == 0);
`else
            exp_cpu = 1'b1;
`endif
            checkOutput("tie_cpu_gnt", int'(cpu_gnt), int'(exp_cpu));
            checkOutput("tie_ld_gnt", int'(ld_gnt), int'(!exp_cpu));
            pushRead(exp_cpu ? 1'b0 : 1'b1, exp_cpu ? 4'h7 : 4'h9);
            if (i == 5) begin
                cpu_req = 1'b0;
                ld_req  = 1'b0;
            end
        end
        @(posedge clk); #1;

        // Table of single accesses, issued back-to-back.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
        end
        @(posedge clk); #1;

        // Reset asserted mid-cycle right after a read is granted.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5;
        @(posedge clk); #1;
        checkOutput("midrst_cpu_gnt", int'(cpu_gnt), 1);
        cpu_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_gnt_async", int'(cpu_gnt), 0);
        checkOutput("midrst_mem_we_async", int'(mem_we), 0);
        @(posedge clk); #1;
        checkOutput("midrst_cpu_rvalid", int'(cpu_rvalid), 0);
        checkOutput("midrst_mem_we", int'(mem_we), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_cpu_rvalid_after", int'(cpu_rvalid), 0);
        checkOutput("midrst_mem_we_after", int'(mem_we), 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 16x4 data memory (`prog_mem`) between the CPU and a loader/debug requester. It sits between the CPU's data-memory port and the memory. A req/gnt handshake serialises accesses, and read data is returned with a registered valid strobe that matches the memory's one-cycle registered-address read. Only one memory access is issued per clock.

## Interface
Parameters:
- `AW`, 4, memory address width.
- `DW`, 4, memory data width.

Ports:
- `clk`  in  1  single system clock; memory is clocked by the same clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt` is seen.
- `cpu_we`  in  1  CPU write enable; stable while `cpu_req` is high.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU access is on the memory this cycle.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid this cycle.
- `cpu_rdata`  out  DW  read data.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_gnt`, `ld_rvalid`, `ld_rdata`: loader port, identical to the CPU port.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_data`  out  DW  memory write data.
- `mem_out`  in  DW  memory read data, valid one cycle after the address is presented.

## Operation
- States: IDLE and ACCESS. Registered owner flag: CPU or LD.
- **Decision (every rising edge in either state):** if any req is high, pick a winner, latch its we/addr/wdata into a command register, and go to ACCESS with owner = winner. Otherwise go to IDLE.
- **Winner selection:**
  - Only one requester asserting: it wins.
  - Both asserting: see Configuration.
- **In ACCESS:**
  - `mem_we`/`mem_addr`/`mem_data` are driven from the command register.
  - The owner's gnt is 1; the other gnt is 0.
- **In IDLE:** `mem_we`=0, `mem_addr`=0, `mem_data`=0, both gnt=0.
- **Requester rule:**
  - req/we/addr/wdata must stay stable from assertion until the cycle gnt is high.
  - req still high in the gnt cycle is a new request. This gives back-to-back accesses with no idle cycle.
- **Read return:** `x_rvalid` is a register set when the previous cycle was ACCESS, owner = x, and we = 0. `x_rdata` = `mem_out` while `x_rvalid`=1, and 0 otherwise.
- **Writes:** complete at the edge ending the gnt cycle. No rvalid is produced.
- A write followed immediately by a read of the same address returns the new data, because memory write and address register share an edge.

## Timing
- **Reset values:** state IDLE, owner CPU, command register 0, all gnt/rvalid/mem_* outputs 0, last-winner pointer = LD (so CPU wins the first tie).
- **Reset mid-access:** state returns to IDLE immediately and asynchronously. Any in-flight rvalid is dropped. The command is lost, and the requester re-requests.
- **Latency:**
  - req sampled at edge E → gnt during cycle E+1.
  - Read data and rvalid during cycle E+2.
- **Throughput:** one access per cycle sustained. rvalid for access N overlaps gnt for access N+1.
- **Single requester, req held high continuously:** granted every cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Ties are resolved by alternation. The requester not granted most recently wins.
  - The pointer updates on every grant.
  - Neither port waits more than one access.
- Undefined:
  - Fixed priority, CPU always wins ties; the loader can starve.
  - Pointer logic is absent.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_ACCESS`);
  - the owner encoding (`OWN_CPU`=0, `OWN_LD`=1);
  - the `mem_cmd_t` struct (we, addr, wdata).
- One sub-module, `arb_pick`: combinational winner select from both reqs, the last-winner pointer and the macro setting. FSM, command register and rvalid logic stay in `mem_arbiter`.

## Test plan
- **Reset:** hold `reset`=0 with both reqs high → all gnt, rvalid and `mem_we` are 0. Release → `cpu_gnt`=1 one cycle later.
- **CPU write then read:** CPU writes addr 3 = 0xA, then reads addr 3 → `mem_we`=1 with `mem_addr`=3 in the gnt cycle. On the read, `cpu_rvalid`=1 with `cpu_rdata`=0xA two cycles after req.
- **Loader preload:** loader writes 0x1..0xF to addrs 1..15 back-to-back with req held → 15 consecutive `ld_gnt` cycles. CPU reads of addr 7 return 0x7.
- **Tie with `MEM_ARB_ROUND_ROBIN_EN`:** both reqs held 6 cycles → gnt order CPU, LD, CPU, LD, CPU, LD.
- **Tie without the macro:** same stimulus → `cpu_gnt` for all 6 cycles, `ld_gnt`=0.
- **Reset mid-read:** CPU read of addr 5 granted, reset pulsed in the next cycle → `cpu_rvalid` stays 0 and `mem_we` stays 0.
